// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register Tnew scoreboard answering D-stage stall/forward queries
// Optional stall-cycle counter enabled by HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
    parameter int TW   = 3,
    parameter int LIFE = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic          issue_rfen,
    input  logic [4:0]    issue_a3,
    input  logic [TW-1:0] issue_tnew,
    input  logic [4:0]    a1_d,
    input  logic [4:0]    a2_d,
    input  logic [TW-1:0] tuse_rs,
    input  logic [TW-1:0] tuse_rt,
    output logic          stall,
    output logic          fwd_rs,
    output logic          fwd_rt
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    localparam int LW = (LIFE < 4) ? 2 : $clog2(LIFE + 1);

    logic [31:0]   busy_q, busy_d;
    logic [TW-1:0] cnt_q  [32];
    logic [TW-1:0] cnt_d  [32];
    logic [LW-1:0] life_q [32];
    logic [LW-1:0] life_d [32];

    logic stall_rs, stall_rt, issue_fire;

    // Queries read pre-edge state only; an issue this cycle becomes visible next cycle.
    always_comb begin
        stall_rs = (a1_d != 5'd0) && busy_q[a1_d] && (cnt_q[a1_d] > tuse_rs);
        stall_rt = (a2_d != 5'd0) && busy_q[a2_d] && (cnt_q[a2_d] > tuse_rt);
        stall    = stall_rs || stall_rt;
        fwd_rs   = (a1_d != 5'd0) && busy_q[a1_d] && (cnt_q[a1_d] == '0);
        fwd_rt   = (a2_d != 5'd0) && busy_q[a2_d] && (cnt_q[a2_d] == '0);
    end

    assign issue_fire = issue_valid && !stall && issue_rfen && (issue_a3 != 5'd0);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        life_d = life_q;
        for (int r = 1; r < 32; r++) begin
            if (busy_q[r]) begin
                cnt_d[r]  = (cnt_q[r] == '0) ? '0 : cnt_q[r] - TW'(1);
                life_d[r] = life_q[r] - LW'(1);
                if (life_q[r] == LW'(1)) begin
                    busy_d[r] = 1'b0;
                end
            end
        end
        // Newest producer wins over the same entry's decrement/retire.
        if (issue_fire) begin
            busy_d[issue_a3] = 1'b1;
            cnt_d[issue_a3]  = issue_tnew;
            life_d[issue_a3] = LW'(LIFE);
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '{default: '0};
            life_q <= '{default: '0};
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            life_q <= life_d;
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else if (stall) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_rfen;
    logic [4:0] issue_a3;
    logic [2:0] issue_tnew;
    logic [4:0] a1_d;
    logic [4:0] a2_d;
    logic [2:0] tuse_rs;
    logic [2:0] tuse_rt;
    logic       stall;
    logic       fwd_rs;
    logic       fwd_rt;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.TW(3), .LIFE(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rfen  (issue_rfen),
        .issue_a3    (issue_a3),
        .issue_tnew  (issue_tnew),
        .a1_d        (a1_d),
        .a2_d        (a2_d),
        .tuse_rs     (tuse_rs),
        .tuse_rt     (tuse_rt),
        .stall       (stall),
        .fwd_rs      (fwd_rs),
        .fwd_rt      (fwd_rt)
`ifdef HAZARD_SCOREBOARD_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then leave 1ns before new inputs are applied.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_rfen  = 1'b0;
        issue_a3    = 5'd0;
        issue_tnew  = 3'd0;
        a1_d        = 5'd0;
        a2_d        = 5'd0;
        tuse_rs     = 3'd7;
        tuse_rt     = 3'd7;
    endtask

    task automatic issue(input logic [4:0] a3, input logic [2:0] tnew);
        issue_valid = 1'b1;
        issue_rfen  = 1'b1;
        issue_a3    = a3;
        issue_tnew  = tnew;
        tick();
        issue_valid = 1'b0;
        issue_rfen  = 1'b0;
        issue_a3    = 5'd0;
    endtask

    task automatic expect_rs(input string tag, input logic s, input logic f);
        #1;
        check({tag, "_stall"}, {31'd0, stall}, {31'd0, s});
        check({tag, "_fwd_rs"}, {31'd0, fwd_rs}, {31'd0, f});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        a1_d  = 5'd5;
        tuse_rs = 3'd0;
        expect_rs("reset_state", 1'b0, 1'b0);
        check("reset_fwd_rt", {31'd0, fwd_rt}, 32'd0);
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();

        // Reset mid-flight
        issue(5'd5, 3'd2);
        a1_d = 5'd5; tuse_rs = 3'd0;
        expect_rs("midflight_pre", 1'b1, 1'b0);
        reset = 1'b1;
        expect_rs("midflight_async", 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_rs("midflight_after", 1'b0, 1'b0);
        idle_inputs();

        // Load-use: cnt 2,1,0 then retire
        issue(5'd8, 3'd2);
        a1_d = 5'd8; tuse_rs = 3'd0;
        expect_rs("lu_cnt2", 1'b1, 1'b0);
        tick();
        expect_rs("lu_cnt1", 1'b1, 1'b0);
        tick();
        expect_rs("lu_cnt0", 1'b0, 1'b1);
        tick();
        expect_rs("lu_retired", 1'b0, 1'b0);
        idle_inputs();

        // Tuse covers Tnew on rt
        issue(5'd9, 3'd1);
        a2_d = 5'd9; tuse_rt = 3'd1;
        #1;
        check("cover_stall", {31'd0, stall}, 32'd0);
        check("cover_fwd_rt0", {31'd0, fwd_rt}, 32'd0);
        tick();
        check("cover_fwd_rt1", {31'd0, fwd_rt}, 32'd1);
        tick(); tick();
        check("cover_retired", {31'd0, fwd_rt}, 32'd0);
        idle_inputs();

        // Retirement after LIFE edges with saturated cnt
        issue(5'd3, 3'd0);
        a1_d = 5'd3; tuse_rs = 3'd0;
        for (int i = 0; i < 3; i++) begin
            expect_rs($sformatf("retire_live%0d", i), 1'b0, 1'b1);
            tick();
        end
        expect_rs("retire_gone", 1'b0, 1'b0);
        idle_inputs();

        // Overwrite restarts cnt and life
        issue(5'd4, 3'd0);
        issue(5'd4, 3'd2);
        a1_d = 5'd4; tuse_rs = 3'd0;
        expect_rs("ovw_cnt2", 1'b1, 1'b0);
        tick();
        expect_rs("ovw_cnt1", 1'b1, 1'b0);
        tick();
        expect_rs("ovw_cnt0", 1'b0, 1'b1);
        tick();
        expect_rs("ovw_retired", 1'b0, 1'b0);
        idle_inputs();

        // rt stall with nonzero Tuse
        issue(5'd12, 3'd3);
        a2_d = 5'd12; tuse_rt = 3'd1;
        #1;
        check("rt_cnt3", {31'd0, stall}, 32'd1);
        tick();
        check("rt_cnt2", {31'd0, stall}, 32'd1);
        tick();
        check("rt_cnt1", {31'd0, stall}, 32'd0);
        tick();
        idle_inputs();

        // Register 0 is never tracked
        issue(5'd0, 3'd2);
        a1_d = 5'd0; tuse_rs = 3'd0;
        expect_rs("r0_query", 1'b0, 1'b0);
        idle_inputs();

        // Issue while stalled is dropped
        issue(5'd10, 3'd3);
        a1_d = 5'd10; tuse_rs = 3'd0;
        #1;
        check("stalled_pre", {31'd0, stall}, 32'd1);
        issue_valid = 1'b1; issue_rfen = 1'b1; issue_a3 = 5'd11; issue_tnew = 3'd2;
        tick();
        issue_valid = 1'b0; issue_rfen = 1'b0; issue_a3 = 5'd0;
        a1_d = 5'd11; tuse_rs = 3'd0;
        expect_rs("stalled_dropped", 1'b0, 1'b0);
        tick(); tick(); tick();
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Per-register scoreboard that consumes the Tnew/A3/RFen bundle launched into the E-stage pipeline register.
- Tracks every in-flight register write and counts down its Tnew each cycle, in the same way the downstream pipeline registers decrement Tnew.
- Answers D-stage operand queries (A1/A2 with Tuse) with a stall decision and a forward-ready indication.
- Sits beside the D stage; its stall output freezes PC/D register and bubbles the E register.

Parameters:
- TW, 3, width of Tnew/Tuse fields.
- LIFE, 3, cycles from issue until the write has landed in the register file (E, M, W); entry retires after LIFE clock edges.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- issue_valid  input  1  D-stage instruction launches into E at this edge (only honoured when stall=0).
- issue_rfen  input  1  launched instruction writes the RF.
- issue_a3  input  5  destination register of the launched instruction.
- issue_tnew  input  TW  cycles until the result exists, relative to E.
- a1_d  input  5  rs of the instruction in D.
- a2_d  input  5  rt of the instruction in D.
- tuse_rs  input  TW  cycles until D needs rs (7 = unused).
- tuse_rt  input  TW  cycles until D needs rt (7 = unused).
- stall  output  1  D must hold; E receives a bubble.
- fwd_rs  output  1  rs is in flight with its value already produced (forward, do not read RF).
- fwd_rt  output  1  rt is in flight with its value already produced.

Behaviour:
- State per register r in 1..31:
  - busy[r] (1 bit).
  - cnt[r] (TW bits): remaining Tnew.
  - life[r] (2+ bits, enough for LIFE): cycles to retirement.
- Register 0 is never tracked; busy[0] is constant 0.
- Reset (async, any time, including mid-countdown): all busy=0, cnt=0, life=0. Outputs stall=0, fwd_rs=0, fwd_rt=0 immediately.
- Each rising edge, for every busy entry:
  - cnt <= (cnt==0) ? 0 : cnt-1, saturating and never wrapping.
  - life <= life-1.
  - When life==1 the entry clears: busy <= 0 on that edge.
- Issue: at an edge with issue_valid & ~stall & issue_rfen & issue_a3!=0:
  - busy[a3] <= 1, cnt[a3] <= issue_tnew, life[a3] <= LIFE.
  - Issue overrides the decrement/retire of the same entry on the same edge (newest producer wins).
- issue_valid with stall=1 is ignored; the bubble carries no write.
- Query logic is combinational from current state:
  - stall_rs = a1_d!=0 & busy[a1_d] & cnt[a1_d] > tuse_rs.
  - stall_rt is the same with a2_d and tuse_rt.
  - stall = stall_rs | stall_rt.
  - fwd_rs = a1_d!=0 & busy[a1_d] & cnt[a1_d]==0; fwd_rt likewise.
- Comparison is unsigned, TW bits.
- A write of r to r (a1_d == issue_a3 at the same edge): the query sees the pre-edge state; the new entry is visible from the next cycle.
- Worst case stall is bounded: cnt strictly decreases, so stall deasserts within 2^TW-1 cycles without issue.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_PERF_EN.
- When defined:
  - Adds output stall_cycles [31:0], counting cycles with stall=1.
  - Cleared by reset; wraps from 0xFFFFFFFF to 0.
- When undefined:
  - The port and counter are absent.
  - Functional behaviour is otherwise identical.

Test Plan:
- Reset mid-flight: issue a3=5,tnew=2; assert reset between edges -> busy cleared at once, stall=0 and fwd_rs=0 for a1_d=5.
- Load-use: issue a3=8,tnew=2; next cycle a1_d=8,tuse_rs=0 -> stall=1 (cnt=1 after edge), then stall=0 and fwd_rs=1 once cnt=0.
- No stall when Tuse covers: issue a3=9,tnew=1; a2_d=9,tuse_rt=1 -> stall=0; fwd_rt=0 then 1 next cycle.
- Retirement: issue a3=3,tnew=0 -> fwd_rs=1 for LIFE=3 cycles, then busy=0, fwd_rs=0 (RF read).
- Overwrite: issue a3=4,tnew=0 then a3=4,tnew=2 next edge -> a1_d=4,tuse_rs=0 stalls 2 cycles.
- Register 0 and stalled issue:
  - issue a3=0,tnew=2 -> a1_d=0 never stalls.
  - issue_valid during stall=1 -> no entry created.
